// File: rtl/id_ex_stage.sv
// ID->EX pipeline stage register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer. Empty slots always hold the all-zero NOP payload.
module id_ex_stage #(
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SKID     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,

  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [ADDR_W-1:0]   id_wd,
  input  logic                id_wreg,
  input  logic [DATA_W-1:0]   id_link_address,

  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [ADDR_W-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [DATA_W-1:0]   ex_link_address
);

  localparam int unsigned PayW = ALUOP_W + ALUSEL_W + 3 * DATA_W + ADDR_W + 1;

  logic [PayW-1:0] in_pay;
  logic [PayW-1:0] m_q, m_d;
  logic [PayW-1:0] s_q, s_d;
  logic            m_valid_q, m_valid_d;
  logic            s_valid_q, s_valid_d;
  logic            accept;
  logic            consume;

  assign in_pay = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg, id_link_address};
  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_link_address} = m_q;
  assign ex_valid = m_valid_q;

  // With the skid buffer, id_ready comes straight from a flop: no path from ex_ready.
  always_comb begin
    if (SKID != 0) begin
      id_ready = !s_valid_q;
    end else begin
      id_ready = ex_ready || !m_valid_q;
    end
  end

  assign accept  = id_valid && id_ready;
  assign consume = m_valid_q && ex_ready;

  always_comb begin
    m_d       = m_q;
    m_valid_d = m_valid_q;
    s_d       = s_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_d       = '0;
      m_valid_d = 1'b0;
      s_d       = '0;
      s_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (s_valid_q) begin
        // Full: input is blocked, only a drain from S into M can happen.
        if (consume) begin
          m_d       = s_q;
          m_valid_d = 1'b1;
          s_d       = '0;
          s_valid_d = 1'b0;
        end
      end else if (accept && (!m_valid_q || consume)) begin
        m_d       = in_pay;
        m_valid_d = 1'b1;
      end else if (accept) begin
        s_d       = in_pay;
        s_valid_d = 1'b1;
      end else if (consume) begin
        m_d       = '0;
        m_valid_d = 1'b0;
      end
    end else begin
      s_d       = '0;
      s_valid_d = 1'b0;
      if (accept) begin
        m_d       = in_pay;
        m_valid_d = 1'b1;
      end else if (consume) begin
        m_d       = '0;
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_q       <= '0;
      m_valid_q <= 1'b0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
      s_q       <= s_d;
      s_valid_q <= s_valid_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a skid instance and a pass-through instance share stimulus and are
// each checked against a FIFO reference model (capacity 2 / capacity 1) every cycle.
module tb_id_ex_stage;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] link;
  } pay_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic id_valid = 1'b0;
  logic ex_ready = 1'b0;
  pay_t id_pay = '0;

  logic id_ready_s, ex_valid_s, id_ready_f, ex_valid_f;
  pay_t obs_s, obs_f;

  pay_t q_s[$];
  pay_t q_f[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.SKID(1)) u_dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready_s),
    .id_aluop(id_pay.aluop), .id_alusel(id_pay.alusel), .id_reg1(id_pay.reg1),
    .id_reg2(id_pay.reg2), .id_wd(id_pay.wd), .id_wreg(id_pay.wreg),
    .id_link_address(id_pay.link),
    .ex_valid(ex_valid_s), .ex_ready(ex_ready),
    .ex_aluop(obs_s.aluop), .ex_alusel(obs_s.alusel), .ex_reg1(obs_s.reg1),
    .ex_reg2(obs_s.reg2), .ex_wd(obs_s.wd), .ex_wreg(obs_s.wreg),
    .ex_link_address(obs_s.link)
  );

  id_ex_stage #(.SKID(0)) u_dut_flow (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready_f),
    .id_aluop(id_pay.aluop), .id_alusel(id_pay.alusel), .id_reg1(id_pay.reg1),
    .id_reg2(id_pay.reg2), .id_wd(id_pay.wd), .id_wreg(id_pay.wreg),
    .id_link_address(id_pay.link),
    .ex_valid(ex_valid_f), .ex_ready(ex_ready),
    .ex_aluop(obs_f.aluop), .ex_alusel(obs_f.alusel), .ex_reg1(obs_f.reg1),
    .ex_reg2(obs_f.reg2), .ex_wd(obs_f.wd), .ex_wreg(obs_f.wreg),
    .ex_link_address(obs_f.link)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pay_t mkpay(input logic [31:0] r1);
    pay_t p;
    p.aluop  = 8'($urandom);
    p.alusel = 3'($urandom);
    p.reg1   = r1;
    p.reg2   = $urandom;
    p.wd     = 5'($urandom);
    p.wreg   = 1'($urandom);
    p.link   = $urandom;
    return p;
  endfunction

  // Drive inputs, compare both DUTs with their models mid-cycle, then advance the models at
  // the rising edge: skid instance is a 2-deep FIFO ready when not full, the other a 1-deep
  // FIFO ready when empty or being drained.
  task automatic step(input logic r, input logic f, input logic v, input pay_t p,
                      input logic er);
    pay_t exp_s, exp_f;
    logic rdy_s, rdy_f;
    rst = r; flush = f; id_valid = v; id_pay = p; ex_ready = er;
    @(negedge clk);
    rdy_s = (q_s.size() < 2);
    rdy_f = er || (q_f.size() == 0);
    exp_s = (q_s.size() != 0) ? q_s[0] : '0;
    exp_f = (q_f.size() != 0) ? q_f[0] : '0;
    chk("skid_ex_valid", 128'(ex_valid_s), 128'(q_s.size() != 0));
    chk("skid_payload", 128'(obs_s), 128'(exp_s));
    chk("skid_id_ready", 128'(id_ready_s), 128'(rdy_s));
    chk("flow_ex_valid", 128'(ex_valid_f), 128'(q_f.size() != 0));
    chk("flow_payload", 128'(obs_f), 128'(exp_f));
    chk("flow_id_ready", 128'(id_ready_f), 128'(rdy_f));
    @(posedge clk);
    if (!r || f) begin
      q_s.delete();
      q_f.delete();
    end else begin
      if (q_s.size() != 0 && er) void'(q_s.pop_front());
      if (v && rdy_s) q_s.push_back(p);
      if (q_f.size() != 0 && er) void'(q_f.pop_front());
      if (v && rdy_f) q_f.push_back(p);
    end
    #1;
  endtask

  initial begin
    pay_t p;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held two cycles with a live input that must not be captured.
    p = '0;
    p.aluop = 8'h21;
    p.reg1  = 32'h5;
    step(1'b0, 1'b0, 1'b1, p, 1'b1);
    step(1'b0, 1'b0, 1'b1, p, 1'b1);

    // Streaming 1..4 back-to-back, then drain with id_valid low.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, mkpay(32'(i)), 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Back-pressure: 10, 11, then 12 waits while execute stalls; release drains in order.
    step(1'b1, 1'b0, 1'b1, mkpay(32'd10), 1'b0);
    step(1'b1, 1'b0, 1'b1, mkpay(32'd11), 1'b0);
    p = mkpay(32'd12);
    step(1'b1, 1'b0, 1'b1, p, 1'b0);
    step(1'b1, 1'b0, 1'b1, p, 1'b0);
    step(1'b1, 1'b0, 1'b1, p, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Flush while full: 12 presented in the flush cycle must never surface.
    step(1'b1, 1'b0, 1'b1, mkpay(32'd10), 1'b0);
    step(1'b1, 1'b0, 1'b1, mkpay(32'd11), 1'b0);
    step(1'b1, 1'b1, 1'b1, mkpay(32'd12), 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), mkpay($urandom), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
